data_mem_access_ctrl: RTL and testbench
=======================================

Name: data_mem_access_ctrl

Overview:
- Sequences core load/store requests onto the single-port, word-addressed data memory.
- Generates the word address, byte enables and lane-replicated write data.
- Waits out variable memory latency with a timeout, then returns lane-aligned load data.
- Sits between the execute stage and data memory. Load data leaves right-justified and zero-filled; sign or zero extension is done by the downstream load-extension unit.

Parameters:
- TIMEOUT, 255, max cycles in WAIT_R before aborting a load with error; 0 disables the timeout.
- CNT_W, $clog2(TIMEOUT+1) (minimum 1), timeout counter width; derived, not overridden.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- core_req  in  1  access request; sampled only while core_ready=1.
- core_we  in  1  1=store, 0=load.
- core_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- core_addr  in  32  byte address.
- core_wdata  in  32  store data, right-justified.
- core_ready  out  1  controller idle and accepting.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  load data shifted so the addressed byte is at [7:0]; bits above the access size are 0.
- rsp_err  out  1  valid with rsp_valid; misaligned, illegal size or timeout.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_be  out  4  byte enables.
- mem_addr  out  32  word address {core_addr[31:2],2'b00}.
- mem_wdata  out  32  lane-replicated write data.
- mem_gnt  in  1  memory accepts request this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read word.

Behaviour:
- Reset (async, rst_n=0): state IDLE, all latched fields 0, counter 0.
  - Reset output values: core_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
  - Reset mid-transaction abandons it; no response is issued.
- FSM states: IDLE, REQ, WAIT_R, RESP. core_ready=1 only in IDLE.
- IDLE:
  - Takes no action unless core_req=1; on core_req=1, latch we/size/addr/wdata.
  - Misaligned or illegal requests go straight to RESP with err=1, rdata=0, and no memory access. Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
  - All other requests go to REQ.
- REQ:
  - mem_req=1, and mem_we/be/addr/wdata are driven from the latched fields.
  - Hold until mem_gnt=1, then:
    - store: go to RESP with err=0.
    - load: go to WAIT_R with the counter cleared.
  - mem_rvalid is ignored in REQ.
- WAIT_R:
  - mem_req=0.
  - On mem_rvalid=1: capture (mem_rdata >> 8*addr[1:0]), masked to the access size, and go to RESP with err=0.
  - If there is no rvalid and TIMEOUT!=0 and counter==TIMEOUT-1: go to RESP with err=1, rdata=0. Otherwise the counter increments.
  - If rvalid and timeout coincide, rvalid wins.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. rsp_rdata/rsp_err hold until the next RESP.
- Stray mem_rvalid in IDLE/RESP (late data after a timeout) is ignored.
- Lane rules:
  - mem_be: byte 0001<<addr[1:0]; half 0011<<{addr[1],1'b0}; word 1111.
  - mem_wdata: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
- Latency:
  - Load with immediate gnt and rvalid next cycle: accept at cycle 0, REQ 1, WAIT_R 2, rsp_valid at cycle 3.
  - Store with immediate gnt: rsp_valid at cycle 2.
  - Error requests: rsp_valid at cycle 1.
- Throughput: one transaction in flight at a time.

Decomposition:
- Package data_mem_ctrl_pkg holds:
  - typedef enum size_e {SZ_B, SZ_H, SZ_W, SZ_ILL}.
  - typedef enum state_e {IDLE, REQ, WAIT_R, RESP}.
  - constants BE_BYTE=4'b0001, BE_HALF=4'b0011, BE_WORD=4'b1111.
  - function misaligned(size, addr[1:0]).
- Sub-module mem_lane_align (combinational): takes size and addr[1:0]; produces be, replicated wdata, aligned and masked rdata. The FSM, latching and timeout counter stay in the top module.

Test Plan:
- Reset then LW at 0x100, gnt immediate, rvalid next with 0xDEADBEEF -> mem_addr=0x100, be=1111, rsp_valid at cycle 3, rdata=0xDEADBEEF, err=0.
- LB at 0x203, rdata=0x80AABBCC -> be=1000, rsp_rdata=0x00000080; LH at 0x202 -> be=1100, rdata=0x000080AA.
- SB at 0x301, wdata=0x12345678, gnt delayed 3 cycles -> mem_req held 3 cycles, be=0010, mem_wdata=0x78787878, rsp_valid, err=0.
- LW at 0x102 and SH at 0x101 -> mem_req never asserted, rsp_valid next cycle with err=1; size=11 -> same.
- TIMEOUT=4, load granted, no rvalid -> rsp_err=1 and rdata=0 after 4 WAIT_R cycles; a late rvalid in IDLE produces no response.
- rst_n low for one cycle during WAIT_R -> immediate IDLE, mem_req=0, core_ready=1, no rsp_valid; the next LW completes normally.

Source files
------------

// File: rtl/data_mem_ctrl_pkg.sv
// Shared types, byte-enable constants and alignment helper for the data memory
// access controller.
package data_mem_ctrl_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_ILL = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        REQ    = 2'b01,
        WAIT_R = 2'b10,
        RESP   = 2'b11
    } state_e;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    function automatic logic misaligned(input size_e size, input logic [1:0] addr_lo);
        case (size)
            SZ_H:    return addr_lo[0];
            SZ_W:    return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: byte enables, replicated store data and
// right-justified, size-masked load data.
module mem_lane_align
    import data_mem_ctrl_pkg::*;
(
    input  size_e       size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_raw,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_aligned
);

    logic [31:0] rdata_shifted;

    assign rdata_shifted = rdata_raw >> {addr_lo, 3'b000};

    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        be            = '0;
        wdata_rep     = '0;
        rdata_aligned = '0;
        case (size)
            SZ_B: begin
                be            = BE_BYTE << addr_lo;
                wdata_rep     = {4{wdata[7:0]}};
                rdata_aligned = {24'h0, rdata_shifted[7:0]};
            end
            SZ_H: begin
                be            = BE_HALF << {addr_lo[1], 1'b0};
                wdata_rep     = {2{wdata[15:0]}};
                rdata_aligned = {16'h0, rdata_shifted[15:0]};
            end
            SZ_W: begin
                be            = BE_WORD;
                wdata_rep     = wdata;
                rdata_aligned = rdata_shifted;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_access_ctrl.sv
// Load/store sequencer between the execute stage and a single-port data memory,
// with a bounded wait for read data.
module data_mem_access_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [1:0]  core_size,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic        core_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e           state_q, state_d;
    logic             we_q, we_d;
    size_e            size_q, size_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;
    size_e       req_size;
    logic        in_req;

    assign req_size = size_e'(core_size);

    mem_lane_align u_lane (
        .size          (size_q),
        .addr_lo       (addr_q[1:0]),
        .wdata         (wdata_q),
        .rdata_raw     (mem_rdata),
        .be            (lane_be),
        .wdata_rep     (lane_wdata),
        .rdata_aligned (lane_rdata)
    );

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (core_req) begin
                    we_d    = core_we;
                    size_d  = req_size;
                    addr_d  = core_addr;
                    wdata_d = core_wdata;
                    // Bad requests never touch memory; they report straight away.
                    if (req_size == SZ_ILL || misaligned(req_size, core_addr[1:0])) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    if (we_q) begin
                        state_d = RESP;
                        err_d   = 1'b0;
                        rdata_d = '0;
                    end else begin
                        state_d = WAIT_R;
                        cnt_d   = '0;
                    end
                end
            end
            WAIT_R: begin
                if (mem_rvalid) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    rdata_d = lane_rdata;
                end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop sees
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= SZ_B;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_req     = (state_q == REQ);
    assign core_ready = (state_q == IDLE);
    assign rsp_valid  = (state_q == RESP);
    assign rsp_rdata  = rdata_q;
    assign rsp_err    = err_q;

    // Memory-side fields are quiet outside REQ so the bus only shows live requests.
    assign mem_req   = in_req;
    assign mem_we    = in_req & we_q;
    assign mem_be    = in_req ? lane_be : 4'b0000;
    assign mem_addr  = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_wdata = in_req ? lane_wdata : 32'h0;

endmodule

// File: tb/tb_data_mem_access_ctrl.sv
// Self-checking bench: directed and random load/store transactions compared
// against a transaction-level model of the controller.
module tb_data_mem_access_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_req;
    logic        core_we;
    logic [1:0]  core_size;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic        core_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    data_mem_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_size  (core_size),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_ready (core_ready),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic model_bad(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
    endfunction

    function automatic logic [31:0] model_be(input logic [1:0] sz, input logic [31:0] a);
        int off = int'(a % 4);
        if (sz == 2'd0) return 32'(1 << off);
        if (sz == 2'd1) return 32'(3 << ((off / 2) * 2));
        return 32'd15;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] w);
        if (sz == 2'd0) return (w & 32'hFF) * 32'h0101_0101;
        if (sz == 2'd1) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] model_rdata(input logic [1:0] sz, input logic [31:0] a,
                                                input logic [31:0] word);
        longint unsigned nbytes = longint'(1) << sz;
        longint unsigned mask = (longint'(1) << (8 * nbytes)) - 1;
        longint unsigned sh = longint'(word) >> (8 * (a % 4));
        return 32'(sh & mask);
    endfunction

    // rv_dly: WAIT_R cycle index carrying rvalid; negative means never.
    task automatic run_txn(input string name, input logic we, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] w, input int gnt_dly,
                           input int rv_dly, input logic [31:0] word);
        logic        bad;
        logic        exp_err;
        logic [31:0] exp_rd;
        bad = model_bad(sz, a);
        if (bad) begin
            exp_err = 1'b1; exp_rd = 32'h0;
        end else if (we) begin
            exp_err = 1'b0; exp_rd = 32'h0;
        end else if (rv_dly < 0 || rv_dly >= TO) begin
            exp_err = 1'b1; exp_rd = 32'h0;
        end else begin
            exp_err = 1'b0; exp_rd = model_rdata(sz, a, word);
        end

        check({name, ".ready_in"}, 32'(core_ready), 32'd1);
        core_req   = 1'b1;
        core_we    = we;
        core_size  = sz;
        core_addr  = a;
        core_wdata = w;
        @(posedge clk); #1;
        core_req   = 1'b0;
        core_addr  = $urandom;
        core_wdata = $urandom;

        if (bad) begin
            check({name, ".no_mem_req"}, 32'(mem_req), 32'd0);
        end else begin
            for (int g = 0; g <= gnt_dly; g++) begin
                check({name, ".mem_req"}, 32'(mem_req), 32'd1);
                check({name, ".early_rsp"}, 32'(rsp_valid), 32'd0);
                if (g == 0) begin
                    check({name, ".mem_addr"}, mem_addr, {a[31:2], 2'b00});
                    check({name, ".mem_be"}, 32'(mem_be), model_be(sz, a));
                    check({name, ".mem_we"}, 32'(mem_we), 32'(we));
                    check({name, ".mem_wdata"}, mem_wdata, model_wdata(sz, w));
                end
                mem_gnt    = (g == gnt_dly);
                mem_rvalid = 1'($urandom_range(0, 1));
                mem_rdata  = $urandom;
                @(posedge clk); #1;
            end
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            if (!we) begin
                for (int k = 0; k < TO; k++) begin
                    check({name, ".wait_mem_req"}, 32'(mem_req), 32'd0);
                    check({name, ".wait_rsp"}, 32'(rsp_valid), 32'd0);
                    mem_rvalid = (k == rv_dly);
                    mem_rdata  = (k == rv_dly) ? word : $urandom;
                    @(posedge clk); #1;
                    mem_rvalid = 1'b0;
                    if (k == rv_dly) break;
                end
            end
        end

        check({name, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({name, ".rsp_err"}, 32'(rsp_err), 32'(exp_err));
        check({name, ".rsp_rdata"}, rsp_rdata, exp_rd);
        check({name, ".ready_resp"}, 32'(core_ready), 32'd0);

        // Late/stray read data while idle must not produce anything.
        mem_rvalid = 1'b1;
        mem_rdata  = $urandom;
        @(posedge clk); #1;
        check({name, ".pulse_one"}, 32'(rsp_valid), 32'd0);
        check({name, ".ready_out"}, 32'(core_ready), 32'd1);
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        check({name, ".stray_rv"}, 32'(rsp_valid), 32'd0);
        check({name, ".hold_err"}, 32'(rsp_err), 32'(exp_err));
        check({name, ".hold_rdata"}, rsp_rdata, exp_rd);
    endtask

    initial begin
        rst_n      = 1'b0;
        core_req   = 1'b0;
        core_we    = 1'b0;
        core_size  = 2'd0;
        core_addr  = 32'h0;
        core_wdata = 32'h0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        #12;
        check("rst.core_ready", 32'(core_ready), 32'd1);
        check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst.rsp_rdata", rsp_rdata, 32'h0);
        check("rst.rsp_err", 32'(rsp_err), 32'd0);
        check("rst.mem_req", 32'(mem_req), 32'd0);
        check("rst.mem_we", 32'(mem_we), 32'd0);
        check("rst.mem_be", 32'(mem_be), 32'd0);
        check("rst.mem_addr", mem_addr, 32'h0);
        check("rst.mem_wdata", mem_wdata, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_txn("lw100", 1'b0, 2'd2, 32'h100, 32'h0, 0, 0, 32'hDEAD_BEEF);
        run_txn("lb203", 1'b0, 2'd0, 32'h203, 32'h0, 0, 0, 32'h80AA_BBCC);
        run_txn("lh202", 1'b0, 2'd1, 32'h202, 32'h0, 0, 1, 32'h80AA_BBCC);
        run_txn("sb301", 1'b1, 2'd0, 32'h301, 32'h1234_5678, 3, 0, 32'h0);
        run_txn("sh302", 1'b1, 2'd1, 32'h302, 32'hCAFE_F00D, 0, 0, 32'h0);
        run_txn("lw102", 1'b0, 2'd2, 32'h102, 32'h0, 0, 0, 32'h1111_1111);
        run_txn("sh101", 1'b1, 2'd1, 32'h101, 32'hFFFF_FFFF, 0, 0, 32'h0);
        run_txn("ill", 1'b0, 2'd3, 32'h100, 32'h0, 0, 0, 32'h2222_2222);
        run_txn("tmo", 1'b0, 2'd2, 32'h104, 32'h0, 1, -1, 32'h3333_3333);
        run_txn("rv_last", 1'b0, 2'd0, 32'h105, 32'h0, 0, TO - 1, 32'h4455_6677);

        // Reset while waiting for read data abandons the load silently.
        core_req  = 1'b1;
        core_we   = 1'b0;
        core_size = 2'd2;
        core_addr = 32'h200;
        @(posedge clk); #1;
        core_req = 1'b0;
        mem_gnt  = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        check("rstw.in_wait", 32'(mem_req), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rstw.mem_req", 32'(mem_req), 32'd0);
        check("rstw.core_ready", 32'(core_ready), 32'd1);
        check("rstw.rsp_valid", 32'(rsp_valid), 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_5555;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rstw.rsp_valid2", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        check("rstw.rsp_valid3", 32'(rsp_valid), 32'd0);
        check("rstw.core_ready2", 32'(core_ready), 32'd1);
        run_txn("lw_after_rst", 1'b0, 2'd2, 32'h100, 32'h0, 0, 0, 32'h0BAD_CAFE);

        for (int i = 0; i < 150; i++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            run_txn("rnd", 1'($urandom_range(0, 1)), sz, a, $urandom,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, TO + 1)) - 1, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
